// File: rtl/flash_spi_rd_pkg.sv
// Shared definitions for the SPI flash read bridge.
//   CMD_READ   : flash READ opcode sent first in every frame
//   FRAME_BITS : command + 24-bit address + two data bytes
//   DATA_BITS  : width of the word returned on the Wishbone side
//   state_t    : Wishbone-side sequencing states
//   flash_addr : byte address sent to the flash for a Wishbone word address
package flash_spi_pkg;

  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam int         FRAME_BITS = 48;
  localparam int         DATA_BITS  = 16;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    ACK
  } state_t;

  // Word address to byte address, offset by the flash base; the 24-bit sum
  // wraps silently.
  function automatic logic [23:0] flash_addr(input logic [23:0] base,
                                             input logic [19:1] adr);
    return base + {4'b0000, adr, 1'b0};
  endfunction

endpackage

// File: rtl/flash_spi_rd_if.sv
// Wishbone slave bus of the SPI flash read bridge.
//   wb_adr_i : word address [19:1]
//   wb_dat_o : 16-bit read data
//   wb_sel_i : byte selects (not used by the bridge)
//   wb_we_i  : write strobe
//   wb_cyc_i : bus cycle
//   wb_stb_i : strobe
//   wb_ack_o : single-cycle acknowledge
interface flash_spi_rd_if;

  logic [19:1] wb_adr_i;
  logic [15:0] wb_dat_o;
  logic [1:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_ack_o;

  modport slave (
    input  wb_adr_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o
  );

  modport master (
    output wb_adr_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o
  );

endinterface

// File: rtl/flash_spi_shift.sv
// SPI mode-0 frame engine: clock divider, sclk generation, 48-bit shift
// register and bit counter.
//   clk, rst : clock, synchronous active-high reset
//   start    : pulse; loads frame, next cycle is the chip-select setup cycle
//   frame    : 48-bit frame to transmit, MSB first
//   miso     : serial input, sampled on the cycle sclk rises
//   sclk     : SPI clock, idles low
//   mosi     : serial output, changes only when sclk falls
//   done     : high in the last cycle of the final sclk high phase
//   rx_data  : last 16 bits received, first received bit in [15]
module flash_spi_shift
  import flash_spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] frame,
  input  logic                  miso,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  done,
  output logic [DATA_BITS-1:0]  rx_data
);

  localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);
  localparam logic [5:0] BIT_RELOAD = 6'(FRAME_BITS - 1);

  logic [7:0]            div_cnt;
  logic [5:0]            bits_left;
  logic [FRAME_BITS-1:0] sreg;
  logic                  armed;
  logic                  running;
  logic                  tick;
  logic                  last_bit;

  assign tick     = running && (div_cnt == 8'd0);
  assign last_bit = (bits_left == 6'd0);
  assign done     = tick && sclk && last_bit;
  assign rx_data  = sreg[DATA_BITS-1:0];

  // Shifting in on the rising edge while mosi is taken from a separate
  // register on the falling edge keeps mosi stable across each high phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt   <= 8'd0;
      bits_left <= 6'd0;
      sreg      <= '0;
      armed     <= 1'b0;
      running   <= 1'b0;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
    end else if (start) begin
      sreg      <= frame;
      mosi      <= frame[FRAME_BITS-1];
      armed     <= 1'b1;
      running   <= 1'b0;
      sclk      <= 1'b0;
      div_cnt   <= DIV_RELOAD;
      bits_left <= BIT_RELOAD;
    end else if (armed) begin
      // chip-select setup cycle: first bit already on mosi, sclk held low
      armed   <= 1'b0;
      running <= 1'b1;
    end else if (running) begin
      if (div_cnt != 8'd0) begin
        div_cnt <= div_cnt - 8'd1;
      end else begin
        div_cnt <= DIV_RELOAD;
        sclk    <= ~sclk;
        if (!sclk) begin
          sreg <= {sreg[FRAME_BITS-2:0], miso};
        end else if (last_bit) begin
          running <= 1'b0;
          mosi    <= 1'b0;
        end else begin
          bits_left <= bits_left - 6'd1;
          mosi      <= sreg[FRAME_BITS-1];
        end
      end
    end
  end

endmodule

// File: rtl/flash_spi_rd.sv
// Wishbone-to-SPI flash read bridge. Reads issue a 03h READ frame for two
// bytes and return them as a little-endian word; writes are acknowledged
// without touching the flash.
//   wb_clk_i : clock
//   wb_rst_i : synchronous active-high reset
//   bus      : Wishbone slave (address, data, strobes, ack)
//   sclk     : SPI clock, mode 0
//   mosi     : SPI data to flash
//   miso     : SPI data from flash
//   ss_n     : flash chip select, active low
module flash_spi_rd
  import flash_spi_pkg::*;
#(
  parameter int          CLK_DIV    = 2,
  parameter logic [23:0] FLASH_BASE = 24'h000000
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  flash_spi_rd_if.slave bus,
  output logic          sclk,
  output logic          mosi,
  input  logic          miso,
  output logic          ss_n
);

  state_t                state;
  state_t                state_nx;
  logic                  req;
  logic                  rd_start;
  logic                  shift_done;
  logic [DATA_BITS-1:0]  rx_data;
  logic [DATA_BITS-1:0]  dat_q;
  logic [FRAME_BITS-1:0] frame;
  logic                  unused_sel;

  assign unused_sel = ^bus.wb_sel_i;

  assign req   = bus.wb_cyc_i & bus.wb_stb_i;
  assign frame = {CMD_READ, flash_addr(FLASH_BASE, bus.wb_adr_i), {DATA_BITS{1'b0}}};

  always_comb begin
    state_nx = state;
    rd_start = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (bus.wb_we_i) begin
            state_nx = ACK;
          end else begin
            state_nx = CS_SETUP;
            rd_start = 1'b1;
          end
        end
      end
      CS_SETUP: state_nx = SHIFT;
      SHIFT:    if (shift_done) state_nx = CS_HOLD;
      CS_HOLD:  state_nx = ACK;
      ACK:      state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Read data is captured while leaving CS_HOLD so it is already valid in
  // the ACK cycle; the write path bypasses CS_HOLD and leaves it untouched.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      dat_q <= '0;
    end else begin
      state <= state_nx;
      if (state == CS_HOLD) begin
        dat_q <= {rx_data[7:0], rx_data[15:8]};
      end
    end
  end

  assign ss_n         = !(state inside {CS_SETUP, SHIFT, CS_HOLD});
  assign bus.wb_ack_o = (state == ACK) && req;
  assign bus.wb_dat_o = dat_q;

  flash_spi_shift #(
    .CLK_DIV (CLK_DIV)
  ) u_shift (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .start   (rd_start),
    .frame   (frame),
    .miso    (miso),
    .sclk    (sclk),
    .mosi    (mosi),
    .done    (shift_done),
    .rx_data (rx_data)
  );

endmodule

// File: doc/flash_spi_rd.md
FLASH_SPI_RD -- requirements
Module: flash_spi_rd

Interface
REQ-001 Parameter CLK_DIV, default 2: clock cycles per SCLK half-period; legal range 1..255.
REQ-002 Parameter FLASH_BASE, default 24'h000000: byte offset added to every flash address.
REQ-003 wb_clk_i  in  1  sole clock; all logic rising-edge.
REQ-004 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-005 wb_adr_i  in  19 [19:1]  Wishbone word address.
REQ-006 wb_dat_o  out 16  read data.
REQ-007 wb_sel_i  in  2  byte selects; ignored.
REQ-008 wb_we_i  in  1  write strobe.
REQ-009 wb_cyc_i, wb_stb_i  in  1 each  Wishbone cycle and strobe.
REQ-010 wb_ack_o  out 1  single-cycle acknowledge.
REQ-011 sclk  out 1  SPI clock, mode 0, idles low.
REQ-012 mosi  out 1  SPI data to flash.
REQ-013 miso  in  1  SPI data from flash.
REQ-014 ss_n  out 1  flash chip select, active low.

Function
REQ-015 A request is wb_cyc_i & wb_stb_i sampled high in IDLE.
REQ-016 A write request SHALL get wb_ack_o one cycle later, issue no SPI activity, and leave wb_dat_o unchanged.
REQ-017 A read request SHALL run the sequence IDLE -> CS_SETUP (1 cycle) -> SHIFT (48 bits) -> CS_HOLD (1 cycle) -> ACK (1 cycle) -> IDLE.
REQ-018 Frame content, MSB first per byte:
- command 8'h03;
- 24-bit address = (FLASH_BASE + {4'b0, wb_adr_i, 1'b0}) mod 2^24, latched at request;
- two data bytes.
REQ-019 The first data byte received goes to wb_dat_o[7:0] and the second to wb_dat_o[15:8] (little-endian word).
REQ-020 ss_n SHALL be low from CS_SETUP through CS_HOLD inclusive, and high otherwise.
REQ-021 Each bit lasts 2*CLK_DIV cycles: sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
REQ-022 miso SHALL be sampled on the cycle sclk rises; mosi SHALL change only on the cycle sclk falls.
REQ-023 The command MSB SHALL be on mosi during CS_SETUP; mosi SHALL be 0 during data bytes and outside frames.
REQ-024 Read latency, request cycle to wb_ack_o high, SHALL be exactly 3 + 96*CLK_DIV cycles (195 at CLK_DIV=2).
REQ-025 wb_dat_o SHALL update on the ACK cycle and hold until the next completed read.
REQ-026 Requests arriving while not in IDLE SHALL be ignored until return to IDLE; ss_n SHALL stay high for at least one cycle between frames.
REQ-027 If wb_cyc_i or wb_stb_i is low on the ACK cycle, the frame still completes and wb_dat_o updates, but wb_ack_o stays low.
REQ-028 Address arithmetic SHALL wrap at 2^24 with no error indication.

Reset
REQ-029 On wb_rst_i, at the next edge:
- wb_ack_o=0, wb_dat_o=16'h0000;
- sclk=0, mosi=0, ss_n=1;
- state=IDLE, bit and divider counters=0.
REQ-030 Reset mid-frame SHALL abort immediately with no ack, and the first post-reset request SHALL start a fresh frame.

Structure
REQ-031 Package flash_spi_pkg SHALL hold: CMD_READ=8'h03, FRAME_BITS=48, DATA_BITS=16, and the state enum {IDLE, CS_SETUP, SHIFT, CS_HOLD, ACK}.
REQ-032 Sub-module flash_spi_shift SHALL hold the divider, sclk generation, 48-bit shift register and bit counter, with start and done handshakes.
REQ-033 The top module SHALL contain the Wishbone FSM and address arithmetic.

Verification
REQ-034 Basic read. CLK_DIV=2, read wb_adr_i=19'h00001, flash model returns 8'hA5 then 8'h3C:
- mosi frame = 03 00 00 02 00 00;
- wb_dat_o=16'h3CA5;
- ack exactly 195 cycles after request.
REQ-035 Base and wrap. FLASH_BASE=24'hFFFFFE, wb_adr_i=19'h00002 -> transmitted address 24'h000002.
REQ-036 Write. wb_we_i=1 -> ack next cycle, ss_n stays high throughout, wb_dat_o unchanged.
REQ-037 Reset mid-frame. wb_rst_i pulsed at bit 20 -> ss_n=1 and sclk=0 next cycle, no ack; a following read returns correct data.
REQ-038 Dropped strobe and back-to-back. wb_stb_i deasserted mid-frame -> frame completes, no ack. Two consecutive reads -> ss_n high >=1 cycle between frames.
REQ-039 Slow divider. CLK_DIV=1 and CLK_DIV=5 -> latency 99 and 483 cycles respectively.
